conv1_window_gen: RTL
=====================

# conv1_window_gen

Sliding-window generator that sits directly upstream of the LeNet `conv1` stage. It accepts a raster-order stream of 16-bit activations, one pixel per beat, for a 32x32 single-channel image. It keeps K-1 rows of line buffer plus a KxK window register, and emits one packed 5x5 window per valid output position. The output drives `conv1`'s `valid` / `input_act` pair directly, so it has no backpressure.

## Interface
- `IMG_W`, default 32: image width in pixels
- `IMG_H`, default 32: image height in pixels
- `K`, default 5: window size
- `DW`, default 16: activation width in bits (signed fixed point, passed through untouched)

- `clk`, input, 1: single clock, rising edge
- `rst`, input, 1: asynchronous, active-high reset
- `in_valid`, input, 1: `in_data` carries the next raster pixel this cycle
- `in_data`, input, DW: pixel value
- `out_valid`, output, 1: `out_window` holds a complete window; connects to `conv1` `valid`
- `out_window`, output, K*K*DW: packed window; connects to `conv1` `input_act`
- `frame_done`, output, 1: one-cycle pulse coincident with the `out_valid` of the last window in a frame

## Operation
- **Pixel counters.** `col` counts 0..IMG_W-1 and `row` counts 0..IMG_H-1. Both give the position of the pixel arriving on the current beat.
  - They advance only on `in_valid`.
  - `col` wraps to 0 after IMG_W-1 and increments `row`.
  - `row` wraps to 0 after IMG_H-1, so the next frame follows with no gap.
- **Line buffers.** There are K-1 rows of IMG_W x DW, indexed by `col`. On each beat, row buffer j is read at `col` and then written at `col` with the value read from buffer j-1; buffer 0 is written with `in_data`.
- **Window shift.** On each beat, all window columns shift one position left (oldest is discarded). The new rightmost column is:
  - rows 0..K-2: the line-buffer reads, oldest row first;
  - row K-1: `in_data`.
- **Packing.** Element k = K*r + c occupies bits [DW*k+DW-1 : DW*k].
  - r = 0 is the top (oldest) row; c = 0 is the leftmost (oldest) column.
  - Element 0 is the top-left pixel and element K*K-1 is the current pixel.
- **Emit condition.** A window is emitted on a beat where `row` >= K-1 and `col` >= K-1. This gives (IMG_H-K+1) x (IMG_W-K+1) = 784 windows per frame at the defaults.
- **Frame end.** The beat at (IMG_H-1, IMG_W-1) also sets `frame_done`.
- **No arithmetic, no saturation.** Data is moved bit-exact.

## Timing
- **Reset.** `out_valid`, `frame_done`, `out_window`, `row`, `col` and all window registers reset to 0. Line-buffer contents need no reset: no window using them can emit before they are rewritten.
- **Latency.** `out_valid`, `out_window` and `frame_done` are registered one cycle after the qualifying `in_valid` beat.
- **Hold between windows.** `out_window` holds its value until the next emitted window. `out_valid` is high for exactly one cycle per window.
- **Stalls.** When `in_valid` is low, counters, buffers and window freeze and `out_valid` goes low the next cycle. Gaps of any length give outputs identical to a gapless stream.
- **Frame boundary.** Consecutive frames are back to back. Stale line-buffer data from frame N is never emitted in frame N+1, because emission is gated by `row` >= K-1.
- **Reset mid-frame.** Everything returns to the reset state asynchronously. The first `in_valid` beat after `rst` deasserts is pixel (0,0).
- **Throughput.** One pixel per clock sustained.

## Configuration
- `CONV1_WIN_SOF_EN` defined: adds an input port `in_sof`, 1 bit.
  - A beat with `in_valid` and `in_sof` both high is treated as pixel (0,0), regardless of the counters, and the counters continue from there.
  - The window registers are cleared on that beat before the shift.
  - This lets the block recover from dropped or extra pixels.
- `CONV1_WIN_SOF_EN` undefined: no `in_sof` port. The counters are realigned only by `rst` and by natural wrap.

## Structure
- **Shared package `conv1_win_pkg`** holds:
  - the default constants IMG_W, IMG_H, K, DW;
  - derived widths `COL_W = $clog2(IMG_W)` and `ROW_W = $clog2(IMG_H)`;
  - typedef `pixel_t` (`logic signed [DW-1:0]`);
  - the window-count constant `WIN_PER_FRAME`.
- **Sub-module `conv1_line_buffer`:** one row of IMG_W x DW, read-before-write at a shared address, enabled by `in_valid`. It is instantiated K-1 times in a chain.
- **Top level** holds the counters, window shift register, emit logic and output registers.

## Test plan
- **First window.** Drive a gapless frame with pixel = row*32 + col.
  - The first `out_valid` comes one cycle after beat 132, i.e. pixel (4,4).
  - `out_window[15:0]` = 0, `out_window[79:64]` = 4, `out_window[335:320]` = 128, `out_window[399:384]` = 132.
- **Window count and frame end.** Over the same frame, count exactly 784 `out_valid` pulses. `frame_done` is high only with the last one, whose element 24 = 1023 and element 0 = 891.
- **Random stalls.** Same frame with random `in_valid` gaps of 0–7 cycles: the window sequence is bit-identical to the gapless run, with no `out_valid` during stalls.
- **Back-to-back frames.** Frame 1 uses values +1000, frame 2 uses +2000.
  - No window mixes rows from both frames.
  - Frame 2's first window element 0 = 2000 and element 24 = 2132.
- **Reset mid-frame.** Assert `rst` mid-frame (at pixel (10,7)), then restart the frame.
  - Outputs are 0 during reset.
  - The first window after restart matches the first-window scenario.
- **Resync, with `CONV1_WIN_SOF_EN`.** Drop 3 pixels in frame 1, then assert `in_sof` at the start of frame 2. Frame 2 windows match the gapless reference exactly.

Source files
------------

// File: rtl/conv1_win_pkg.sv
// Shared constants and types for the conv1 sliding-window generator.
package conv1_win_pkg;
    localparam int IMG_W = 32;
    localparam int IMG_H = 32;
    localparam int K     = 5;
    localparam int DW    = 16;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam int WIN_PER_FRAME = (IMG_H - K + 1) * (IMG_W - K + 1);

    typedef logic signed [DW-1:0] pixel_t;
endpackage

// File: rtl/conv1_window_gen_line_buffer.sv
// One image row of pixel storage with read-before-write at a shared address.
module conv1_line_buffer
    import conv1_win_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int WIDTH = DW,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The read must see the old row in the same beat that overwrites it.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv1_window_gen.sv
// KxK sliding-window generator feeding conv1; one packed window per valid position.
// Optional start-of-frame resync input enabled by defining CONV1_WIN_SOF_EN.
module conv1_window_gen #(
    parameter int IMG_W = conv1_win_pkg::IMG_W,
    parameter int IMG_H = conv1_win_pkg::IMG_H,
    parameter int K     = conv1_win_pkg::K,
    parameter int DW    = conv1_win_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
`ifdef CONV1_WIN_SOF_EN
    input  logic              in_sof,
`endif
    output logic              out_valid,
    output logic [K*K*DW-1:0] out_window,
    output logic              frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NE = K * K;

    logic [CW-1:0]    col_q, col_d, col_cur;
    logic [RW-1:0]    row_q, row_d, row_cur;
    logic [NE*DW-1:0] win_q, win_d, win_base;
    logic [NE*DW-1:0] out_window_q, out_window_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             sof;
    logic             emit;
    logic [DW-1:0]    lb_rd   [K-1];
    logic [DW-1:0]    new_col [K];

`ifdef CONV1_WIN_SOF_EN
    assign sof = in_valid & in_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame beat is pixel (0,0) and starts from an empty window.
    assign col_cur  = sof ? '0 : col_q;
    assign row_cur  = sof ? '0 : row_q;
    assign win_base = sof ? '0 : win_q;

    genvar gi;
    generate
        for (gi = 0; gi < K-1; gi++) begin : g_lb
            logic [DW-1:0] wr_data;
            if (gi == 0) begin : g_head
                assign wr_data = in_data;
            end else begin : g_link
                assign wr_data = lb_rd[gi-1];
            end
            conv1_line_buffer #(
                .DEPTH (IMG_W),
                .WIDTH (DW),
                .AW    (CW)
            ) u_lb (
                .clk     (clk),
                .en      (in_valid),
                .addr    (col_cur),
                .wr_data (wr_data),
                .rd_data (lb_rd[gi])
            );
        end

        // Buffer K-2 holds the oldest row, so it lands in the top window row.
        for (gi = 0; gi < K; gi++) begin : g_col
            if (gi < K-1) begin : g_buf
                assign new_col[gi] = lb_rd[K-2-gi];
            end else begin : g_cur
                assign new_col[gi] = in_data;
            end
        end
    endgenerate

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_cur == CW'(IMG_W-1)) begin
                col_d = '0;
                row_d = (row_cur == RW'(IMG_H-1)) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
        end
    end

    always_comb begin
        win_d = win_q;
        if (in_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c < K-1) begin
                        win_d[DW*(K*r+c) +: DW] = win_base[DW*(K*r+c+1) +: DW];
                    end else begin
                        win_d[DW*(K*r+c) +: DW] = new_col[r];
                    end
                end
            end
        end
    end

    always_comb begin
        emit         = in_valid && (row_cur >= RW'(K-1)) && (col_cur >= CW'(K-1));
        out_valid_d  = emit;
        frame_done_d = emit && (row_cur == RW'(IMG_H-1)) && (col_cur == CW'(IMG_W-1));
        out_window_d = emit ? win_d : out_window_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_window_q <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_window_q <= out_window_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign frame_done = frame_done_q;

endmodule
